conv_psum_collector: RTL and testbench

- Receiving end of the convolution adder tree: consumes the 7-bit two's-complement row sums produced by adder stage 2, one per clock when valid.
- Accumulates ROWS row sums per output pixel and adds a per-kernel bias.
- Applies optional ReLU and saturation, then queues each finished pixel in a small FIFO.
- Drains the FIFO over a valid/ready interface toward the pooling/writeback stage.

---
 rtl/conv_pkg.sv | 52 +++++
 rtl/conv_psum_collector_if.sv | 36 +++
 rtl/conv_result_fifo.sv | 58 +++++
 rtl/conv_psum_collector.sv | 116 +++++++++++
 tb/tb_conv_psum_collector.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg : shared widths and result conversion for convolution collectors
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

  localparam int PSUM_W = 7;
  localparam int BIAS_W = 8;
  localparam int ACC_W  = 10;
  localparam int OUT_W  = 8;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } sat_res_t;

  localparam acc_t ACC_ZERO  = '0;
  localparam acc_t ACC_U_MAX = acc_t'((2 ** OUT_W) - 1);
  localparam acc_t ACC_S_MAX = acc_t'((2 ** (OUT_W - 1)) - 1);
  localparam acc_t ACC_S_MIN = acc_t'(-(2 ** (OUT_W - 1)));

  // ReLU zeroing is not a saturation; only clamping to a limit flags sat.
  function automatic sat_res_t sat_relu(input acc_t sum, input logic relu_en);
    sat_res_t r;
    r.data = sum[OUT_W-1:0];
    r.sat  = 1'b0;
    if (relu_en) begin
      if (sum < ACC_ZERO) begin
        r.data = '0;
      end else if (sum > ACC_U_MAX) begin
        r.data = ACC_U_MAX[OUT_W-1:0];
        r.sat  = 1'b1;
      end
    end else begin
      if (sum > ACC_S_MAX) begin
        r.data = ACC_S_MAX[OUT_W-1:0];
        r.sat  = 1'b1;
      end else if (sum < ACC_S_MIN) begin
        r.data = ACC_S_MIN[OUT_W-1:0];
        r.sat  = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_psum_collector_if.sv
// ----------------------------------------------------------------------------
// conv_psum_collector_if : row-sum input, pixel output and status bundle
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface conv_psum_collector_if;
  import conv_pkg::*;

  logic [PSUM_W-1:0] psum_in;
  logic              psum_valid;
  logic              psum_first;
  logic [BIAS_W-1:0] bias;
  logic              relu_en;
  logic              in_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              drop_err;
  logic              sync_err;
  logic              sat_seen;

  // Environment side: adder stage 2 upstream and pooling/writeback downstream.
  modport master (
    output psum_in, psum_valid, psum_first, bias, relu_en, out_ready,
    input  in_ready, out_data, out_valid, drop_err, sync_err, sat_seen
  );

  modport slave (
    input  psum_in, psum_valid, psum_first, bias, relu_en, out_ready,
    output in_ready, out_data, out_valid, drop_err, sync_err, sat_seen
  );

endinterface

`default_nettype wire

// File: rtl/conv_result_fifo.sv
// ----------------------------------------------------------------------------
// conv_result_fifo : synchronous FIFO, combinational head read, zero when empty
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_psum_collector.sv
// ----------------------------------------------------------------------------
// conv_psum_collector : accumulates ROWS row sums + bias per pixel, clamps, queues
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv_psum_collector
  import conv_pkg::*;
#(
  parameter int ROWS       = 3,
  parameter int FIFO_DEPTH = 4
) (
  input wire logic            clk,
  input wire logic            rst_n,
  conv_psum_collector_if.slave bus
);

  localparam int                CNT_W    = $clog2(ROWS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ROWS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  acc_t             acc_q, acc_d;
  logic             drop_q, drop_d;
  logic             sync_q, sync_d;
  logic             sat_q, sat_d;

  acc_t             psum_ext;
  acc_t             bias_ext;
  acc_t             sum;
  logic             restart;
  logic             last;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_head;
  sat_res_t         res;

  assign psum_ext = acc_t'(signed'(bus.psum_in));
  assign bias_ext = acc_t'(signed'(bus.bias));

  // A beat with cnt==0 starts a pixel whether or not psum_first is raised.
  always_comb begin
    restart = bus.psum_first || (cnt_q == '0);
    sum     = restart ? (bias_ext + psum_ext) : (acc_q + psum_ext);
    last    = bus.psum_valid && !restart && (cnt_q == CNT_LAST);
    res     = sat_relu(sum, bus.relu_en);
    push    = last && !fifo_full;
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    drop_d = drop_q;
    sync_d = sync_q;
    sat_d  = sat_q;
    if (bus.psum_valid) begin
      acc_d = sum;
      if (last) begin
        cnt_d = '0;
      end else if (restart) begin
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (bus.psum_first && (cnt_q != '0)) begin
        sync_d = 1'b1;
      end
      if (last && fifo_full) begin
        drop_d = 1'b1;
      end
      if (last && res.sat) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      drop_q <= 1'b0;
      sync_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      drop_q <= drop_d;
      sync_q <= sync_d;
      sat_q  <= sat_d;
    end
  end

  conv_result_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (res.data),
    .pop_i   (bus.out_ready),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.drop_err  = drop_q;
  assign bus.sync_err  = sync_q;
  assign bus.sat_seen  = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_psum_collector.sv
// ----------------------------------------------------------------------------
// tb_conv_psum_collector : directed scenarios plus randomized scoreboard run
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_conv_psum_collector;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  conv_psum_collector_if bus ();

  conv_psum_collector #(
    .ROWS       (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Pixel value from the arithmetic rules: total = bias + row sums, then clamp.
  function automatic int model_pixel(input int total, input bit relu, output bit sat);
    int t;
    t   = total;
    sat = 1'b0;
    if (relu) begin
      if (t < 0) t = 0;
      else if (t > 255) begin t = 255; sat = 1'b1; end
    end else begin
      if (t > 127) begin t = 127; sat = 1'b1; end
      else if (t < -128) begin t = -128; sat = 1'b1; end
    end
    return t & 255;
  endfunction

  task automatic send_beat(input int p, input bit first, input int b, input bit relu);
    bus.psum_in    = 7'(p);
    bus.psum_first = first;
    bus.bias       = 8'(b);
    bus.relu_en    = relu;
    bus.psum_valid = 1'b1;
    @(posedge clk); #1;
    bus.psum_valid = 1'b0;
    bus.psum_first = 1'b0;
  endtask

  task automatic send_pixel(input int b, input int p0, input int p1, input int p2, input bit relu);
    send_beat(p0, 1'b1, b, relu);
    send_beat(p1, 1'b0, b, relu);
    send_beat(p2, 1'b0, b, relu);
  endtask

  task automatic pop_one;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.out_valid, bus.out_data, bus.in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b data=%0h ready=%0b expected 0 0 1",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    n_tests++;
    if ({bus.drop_err, bus.sync_err, bus.sat_seen} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %0b%0b%0b expected 000", bus.drop_err, bus.sync_err, bus.sat_seen);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit s;
    int e;
    send_beat(10, 1'b1, 5, 1'b1);
    send_beat(20, 1'b0, 5, 1'b1);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_valid: got %0b expected 0", bus.out_valid);
    end
    send_beat(-3, 1'b0, 5, 1'b1);
    e = model_pixel(5 + 10 + 20 - 3, 1'b1, s);
    n_tests++;
    if ({bus.out_valid, bus.out_data, bus.sat_seen} !== {1'b1, 8'(e), s}) begin
      n_fail++;
      $display("FAIL basic_pixel: got valid=%0b data=%0d sat=%0b expected 1 %0d %0b",
               bus.out_valid, bus.out_data, bus.sat_seen, e, s);
    end
    pop_one();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_pop: got valid=%0b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_clamp(input string name, input int b, input int p0, input int p1,
                            input int p2, input bit relu, input int want, input bit want_sat);
    bit s;
    int e;
    send_pixel(b, p0, p1, p2, relu);
    e = model_pixel(b + p0 + p1 + p2, relu, s);
    n_tests++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'(want)} || e != want) begin
      n_fail++;
      $display("FAIL %s_data: got valid=%0b data=%0h expected 1 %0h (model %0h)",
               name, bus.out_valid, bus.out_data, want, e);
    end
    n_tests++;
    if (bus.sat_seen !== want_sat) begin
      n_fail++;
      $display("FAIL %s_sat: got %0b expected %0b", name, bus.sat_seen, want_sat);
    end
    pop_one();
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_pixel(0, k, 0, 0, 1'b0);
    n_tests++;
    if ({bus.in_ready, bus.drop_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_full: got in_ready=%0b drop=%0b expected 0 0", bus.in_ready, bus.drop_err);
    end
    send_pixel(0, 5, 0, 0, 1'b0);
    n_tests++;
    if ({bus.drop_err, bus.out_valid, bus.out_data} !== {1'b1, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL bp_drop: got drop=%0b valid=%0b head=%0d expected 1 1 1",
               bus.drop_err, bus.out_valid, bus.out_data);
    end
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, 8'(k)}) begin
        n_fail++;
        $display("FAIL bp_drain: got valid=%0b data=%0d expected 1 %0d", bus.out_valid, bus.out_data, k);
      end
      pop_one();
    end
    n_tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_empty: got valid=%0b in_ready=%0b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_resync;
    send_beat(7, 1'b1, 0, 1'b0);
    send_beat(8, 1'b0, 0, 1'b0);
    send_pixel(0, 1, 2, 3, 1'b0);
    n_tests++;
    if ({bus.sync_err, bus.out_valid, bus.out_data} !== {1'b1, 1'b1, 8'd6}) begin
      n_fail++;
      $display("FAIL resync: got sync=%0b valid=%0b data=%0d expected 1 1 6",
               bus.sync_err, bus.out_valid, bus.out_data);
    end
    pop_one();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_single: got valid=%0b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_pixel;
    send_beat(9, 1'b1, 0, 1'b0);
    send_beat(9, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_tests++;
    if ({bus.out_valid, bus.out_data, bus.drop_err, bus.sync_err, bus.sat_seen} !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_clear: got valid=%0b data=%0h flags=%0b%0b%0b expected all 0",
               bus.out_valid, bus.out_data, bus.drop_err, bus.sync_err, bus.sat_seen);
    end
    send_pixel(0, 4, 4, 4, 1'b0);
    n_tests++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 8'd12}) begin
      n_fail++;
      $display("FAIL midreset_pixel: got valid=%0b data=%0d expected 1 12", bus.out_valid, bus.out_data);
    end
    pop_one();
  endtask

  task automatic test_random;
    int q[$];
    int rows = 0, part = 0, e = 0;
    bit m_drop = 0, m_sync = 0, m_sat = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit v, f, r, rdy, s, pop, push;
      int p, b;
      v   = ($urandom_range(0, 3) != 0);
      p   = int'($urandom_range(0, 127)) - 64;
      b   = int'($urandom_range(0, 255)) - 128;
      r   = 1'($urandom_range(0, 1));
      rdy = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      f   = (rows == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      n_tests++;
      if (bus.out_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL rand_valid: cycle %0d got %0b expected %0b", cyc, bus.out_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_tests++;
        if (bus.out_data !== 8'(q[0])) begin
          n_fail++;
          $display("FAIL rand_data: cycle %0d got %0h expected %0h", cyc, bus.out_data, q[0]);
        end
      end
      bus.psum_valid = v;
      bus.psum_first = f;
      bus.psum_in    = 7'(p);
      bus.bias       = 8'(b);
      bus.relu_en    = r;
      bus.out_ready  = rdy;
      pop  = rdy && (q.size() != 0);
      push = 1'b0;
      if (v) begin
        if (f && rows != 0) m_sync = 1'b1;
        if (f || rows == 0) begin
          part = b + p;
          rows = 1;
        end else begin
          part += p;
          rows++;
          if (rows == 3) begin
            rows = 0;
            e = model_pixel(part, r, s);
            if (s) m_sat = 1'b1;
            if (q.size() == 4) m_drop = 1'b1;
            else push = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
    end
    bus.psum_valid = 1'b0;
    bus.out_ready  = 1'b0;
    n_tests++;
    if ({bus.drop_err, bus.sync_err, bus.sat_seen} !== {m_drop, m_sync, m_sat}) begin
      n_fail++;
      $display("FAIL rand_flags: got %0b%0b%0b expected %0b%0b%0b",
               bus.drop_err, bus.sync_err, bus.sat_seen, m_drop, m_sync, m_sat);
    end
  endtask

  initial begin
    bus.psum_in    = '0;
    bus.psum_valid = 1'b0;
    bus.psum_first = 1'b0;
    bus.bias       = '0;
    bus.relu_en    = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_clamp("neg_relu",   0,   -20, -30, -10, 1'b1, 8'h00, 1'b0);
    test_clamp("neg_signed", 0,   -20, -30, -10, 1'b0, 8'hC4, 1'b0);
    test_clamp("sat_relu",   127,  63,  63,  63, 1'b1, 8'hFF, 1'b1);
    test_clamp("sat_signed", 127,  63,  63,  63, 1'b0, 8'h7F, 1'b1);
    test_backpressure();
    test_resync();
    test_reset_mid_pixel();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
